// File: rtl/pcie_c2f_assembler_if.sv
// Register-bus write port and FWFT commit stream of the c2f write assembler.
// The master side is the host/consumer; the slave side is the assembler.
interface pcie_c2f_assembler_if #(
    parameter int DATA_WORDS = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_IDX_W  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [REG_IDX_W-1:0]    rx_index;
    logic [31:0]             rx_data;
    logic                    rx_valid;
    logic [ADDR_WIDTH-1:0]   c2f_addr;
    logic [32*DATA_WORDS-1:0] c2f_data;
    logic                    c2f_valid;
    logic                    c2f_ready;
    logic [LVL_W-1:0]        level;
    logic                    overflow;

    modport master (
        output rx_index, rx_data, rx_valid, c2f_ready,
        input  c2f_addr, c2f_data, c2f_valid, level, overflow
    );

    modport slave (
        input  rx_index, rx_data, rx_valid, c2f_ready,
        output c2f_addr, c2f_data, c2f_valid, level, overflow
    );
endinterface

// File: rtl/pcie_c2f_assembler.sv
// Assembles host 32-bit register writes into wide {addr, data} commits and queues them
// in a FWFT FIFO with registered head outputs, optional address auto-increment and overflow flag.
module pcie_c2f_assembler #(
    parameter int DATA_WORDS = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_IDX_W  = 8,
    parameter int BASE_REG   = 253,
    parameter int FIFO_DEPTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    pcie_c2f_assembler_if.slave bus
);
    localparam int DATA_W = 32 * DATA_WORDS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [31:0] IDX_CTRL = 32'(BASE_REG - 1);
    localparam logic [31:0] IDX_ADDR = 32'(BASE_REG);

    logic [31:0]           idx;
    logic                  wr_ctrl;
    logic                  wr_addr;
    logic                  wr_top;
    logic [DATA_WORDS-1:0] word_sel;

    logic [ADDR_WIDTH-1:0] staging_addr;
    logic [31:0]           staging_data [DATA_WORDS];
    logic                  auto_inc;

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_next;
    logic [LVL_W-1:0]      count;
    logic [LVL_W-1:0]      count_next;

    logic                  pop;
    logic                  full;
    logic                  push;
    logic                  reject;
    logic                  bypass;
    logic [DATA_W-1:0]     push_data;

    assign idx     = 32'(bus.rx_index);
    assign wr_ctrl = bus.rx_valid && (idx == IDX_CTRL);
    assign wr_addr = bus.rx_valid && (idx == IDX_ADDR);

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < DATA_WORDS; k++) begin
            word_sel[k] = bus.rx_valid && (idx == 32'(BASE_REG + 1 + k));
        end
    end

    assign wr_top = word_sel[DATA_WORDS-1];

    // Top word comes straight from the bus so the commit carries this cycle's write.
    always_comb begin
        push_data = '0;
        for (int k = 0; k < DATA_WORDS - 1; k++) begin
            push_data[32*k +: 32] = staging_data[k];
        end
        push_data[32*(DATA_WORDS-1) +: 32] = bus.rx_data;
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the commit.
    assign pop    = bus.c2f_valid && bus.c2f_ready;
    assign full   = (count == LVL_W'(FIFO_DEPTH));
    assign push   = wr_top && (!full || pop);
    assign reject = wr_top && full && !pop;

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + LVL_W'(1);
            2'b01:   count_next = count - LVL_W'(1);
            default: count_next = count;
        endcase
    end

    assign rd_next = rd_ptr + PTR_W'(pop);

    // The pushed entry becomes the head when nothing older remains after this edge.
    assign bypass = push && ((count == '0) || ((count == LVL_W'(1)) && pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_addr <= '0;
            auto_inc     <= 1'b0;
            bus.overflow <= 1'b0;
            for (int k = 0; k < DATA_WORDS; k++) begin
                staging_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DATA_WORDS; k++) begin
                if (word_sel[k]) begin
                    staging_data[k] <= bus.rx_data;
                end
            end
            if (wr_addr) begin
                staging_addr <= bus.rx_data[ADDR_WIDTH-1:0];
            end else if (push && auto_inc) begin
                staging_addr <= staging_addr + ADDR_WIDTH'(1);
            end
            if (wr_ctrl) begin
                auto_inc <= bus.rx_data[1];
                if (bus.rx_data[0]) begin
                    bus.overflow <= 1'b0;
                end
            end
            if (reject) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= staging_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            bus.c2f_valid <= 1'b0;
            bus.c2f_addr  <= '0;
            bus.c2f_data  <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            bus.c2f_valid <= (count_next != '0);
            if (count_next == '0) begin
                bus.c2f_addr <= '0;
                bus.c2f_data <= '0;
            end else if (bypass) begin
                bus.c2f_addr <= staging_addr;
                bus.c2f_data <= push_data;
            end else begin
                bus.c2f_addr <= mem_addr[rd_next];
                bus.c2f_data <= mem_data[rd_next];
            end
        end
    end

    assign bus.level = count;
endmodule

// File: tb/tb_pcie_c2f_assembler.sv
// Directed bench for pcie_c2f_assembler: a default instance plus a 4-word, 20-bit-address instance.
module tb_pcie_c2f_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pcie_c2f_assembler_if #(.DATA_WORDS(2), .ADDR_WIDTH(32), .REG_IDX_W(8), .FIFO_DEPTH(16)) bus0 ();
    pcie_c2f_assembler_if #(.DATA_WORDS(4), .ADDR_WIDTH(20), .REG_IDX_W(9), .FIFO_DEPTH(16)) bus1 ();

    pcie_c2f_assembler #(.DATA_WORDS(2), .ADDR_WIDTH(32), .REG_IDX_W(8), .BASE_REG(253), .FIFO_DEPTH(16))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pcie_c2f_assembler #(.DATA_WORDS(4), .ADDR_WIDTH(20), .REG_IDX_W(9), .BASE_REG(253), .FIFO_DEPTH(16))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One register write, sampled at the posedge between the two negedges.
    task automatic wr0(input int index, input logic [31:0] data);
        @(negedge clk);
        bus0.rx_index = 8'(index);
        bus0.rx_data  = data;
        bus0.rx_valid = 1'b1;
        @(negedge clk);
        bus0.rx_valid = 1'b0;
    endtask

    task automatic wr1(input int index, input logic [31:0] data);
        @(negedge clk);
        bus1.rx_index = 9'(index);
        bus1.rx_data  = data;
        bus1.rx_valid = 1'b1;
        @(negedge clk);
        bus1.rx_valid = 1'b0;
    endtask

    initial begin
        bus0.rx_index = '0; bus0.rx_data = '0; bus0.rx_valid = 1'b0; bus0.c2f_ready = 1'b0;
        bus1.rx_index = '0; bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.c2f_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_valid", 128'(bus0.c2f_valid), 128'd0);
        check("rst_level", 128'(bus0.level), 128'd0);
        check("rst_ovf", 128'(bus0.overflow), 128'd0);
        check("rst_addr", 128'(bus0.c2f_addr), 128'd0);
        check("rst_data", 128'(bus0.c2f_data), 128'd0);

        // single beat
        bus0.c2f_ready = 1'b1;
        wr0(253, 32'h0000_1000);
        wr0(254, 32'hAAAA_5555);
        check("t1_pre_valid", 128'(bus0.c2f_valid), 128'd0);
        wr0(255, 32'h1234_5678);
        check("t1_valid", 128'(bus0.c2f_valid), 128'd1);
        check("t1_addr", 128'(bus0.c2f_addr), 128'h1000);
        check("t1_data", 128'(bus0.c2f_data), 128'h1234_5678_AAAA_5555);
        @(negedge clk);
        check("t1_valid_drop", 128'(bus0.c2f_valid), 128'd0);
        check("t1_level", 128'(bus0.level), 128'd0);

        // auto-increment with address wrap
        bus0.c2f_ready = 1'b0;
        wr0(252, 32'h2);
        wr0(253, 32'hFFFF_FFFF);
        wr0(255, 32'h1);
        wr0(255, 32'h2);
        wr0(255, 32'h3);
        @(negedge clk);
        check("t2_level", 128'(bus0.level), 128'd3);
        check("t2_addr0", 128'(bus0.c2f_addr), 128'hFFFF_FFFF);
        check("t2_data0", 128'(bus0.c2f_data), 128'h0000_0001_AAAA_5555);
        bus0.c2f_ready = 1'b1;
        @(negedge clk);
        check("t2_addr1", 128'(bus0.c2f_addr), 128'h0);
        check("t2_data1", 128'(bus0.c2f_data), 128'h0000_0002_AAAA_5555);
        @(negedge clk);
        check("t2_addr2", 128'(bus0.c2f_addr), 128'h1);
        check("t2_data2", 128'(bus0.c2f_data), 128'h0000_0003_AAAA_5555);
        @(negedge clk);
        check("t2_empty", 128'(bus0.c2f_valid), 128'd0);
        bus0.c2f_ready = 1'b0;
        wr0(252, 32'h0);

        // overflow on the 17th commit
        wr0(253, 32'h100);
        for (int i = 0; i < 17; i++) wr0(255, 32'(i));
        @(negedge clk);
        check("t3_level", 128'(bus0.level), 128'd16);
        check("t3_ovf", 128'(bus0.overflow), 128'd1);
        bus0.c2f_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_beat_addr", 128'(bus0.c2f_addr), 128'h100);
            check("t3_beat_data", 128'(bus0.c2f_data), {64'd0, 32'(i), 32'hAAAA_5555});
            @(negedge clk);
        end
        check("t3_empty", 128'(bus0.c2f_valid), 128'd0);
        bus0.c2f_ready = 1'b0;
        check("t3_ovf_sticky", 128'(bus0.overflow), 128'd1);
        wr0(252, 32'h1);
        check("t3_ovf_clear", 128'(bus0.overflow), 128'd0);

        // commit to a full FIFO alongside a pop
        for (int i = 0; i < 16; i++) wr0(255, 32'h40 + 32'(i));
        @(negedge clk);
        check("t4_full", 128'(bus0.level), 128'd16);
        bus0.rx_index  = 8'd255;
        bus0.rx_data   = 32'h99;
        bus0.rx_valid  = 1'b1;
        bus0.c2f_ready = 1'b1;
        @(negedge clk);
        bus0.rx_valid  = 1'b0;
        bus0.c2f_ready = 1'b0;
        check("t4_level", 128'(bus0.level), 128'd16);
        check("t4_ovf", 128'(bus0.overflow), 128'd0);
        check("t4_head", 128'(bus0.c2f_data), 128'h0000_0041_AAAA_5555);
        bus0.c2f_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_last", 128'(bus0.c2f_data), 128'h0000_0099_AAAA_5555);
        @(negedge clk);
        check("t4_empty", 128'(bus0.c2f_valid), 128'd0);
        bus0.c2f_ready = 1'b0;

        // reset with content queued and address staged
        wr0(253, 32'h777);
        for (int i = 0; i < 5; i++) wr0(255, 32'h50 + 32'(i));
        @(negedge clk);
        check("t5_level_pre", 128'(bus0.level), 128'd5);
        rst = 1'b1;
        #1;
        check("t5_valid", 128'(bus0.c2f_valid), 128'd0);
        check("t5_level", 128'(bus0.level), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        wr0(255, 32'h5);
        check("t5_addr", 128'(bus0.c2f_addr), 128'h0);
        check("t5_data", 128'(bus0.c2f_data), 128'h0000_0005_0000_0000);
        check("t5_level_post", 128'(bus0.level), 128'd1);

        // wide instance, out-of-order words, truncated address
        wr1(256, 32'h3333_3333);
        wr1(254, 32'h1111_1111);
        wr1(255, 32'h2222_2222);
        wr1(253, 32'hABCD_E123);
        wr1(258, 32'hDEAD_BEEF);
        check("t6_ignored_level", 128'(bus1.level), 128'd0);
        check("t6_ignored_valid", 128'(bus1.c2f_valid), 128'd0);
        wr1(257, 32'h4444_4444);
        check("t6_level", 128'(bus1.level), 128'd1);
        check("t6_addr", 128'(bus1.c2f_addr), 128'hDE123);
        check("t6_data", 128'(bus1.c2f_data), 128'h4444_4444_3333_3333_2222_2222_1111_1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
